// File: rtl/jump_pkg.sv
// Shared types and helpers for the jump game sequencer.
// Contents: state encoding, datapath widths, absolute-distance helper.
package jump_pkg;

  localparam int unsigned STATE_W  = 3;
  localparam int unsigned X_W      = 32;
  localparam int unsigned CHARGE_W = 8;

  typedef enum logic [STATE_W-1:0] {
    IDLE   = 3'd0,
    READY  = 3'd1,
    CHARGE = 3'd2,
    JUMP   = 3'd3,
    JUDGE  = 3'd4,
    RELOAD = 3'd5,
    OVER   = 3'd6
  } state_t;

  // |a - b| through a 33-bit subtract so any pair of 32-bit positions is exact.
  function automatic logic [X_W:0] abs_dist(input logic [X_W-1:0] a, input logic [X_W-1:0] b);
    logic [X_W:0] d;
    d = {1'b0, a} - {1'b0, b};
    return d[X_W] ? (~d + (X_W+1)'(1)) : d;
  endfunction

endpackage

// File: rtl/jump_game_ctrl_if.sv
// Player/block/reload signal bundle of the jump game sequencer.
// master: drives button, block positions and reload_done; slave: the sequencer.
interface jump_game_ctrl_if
  import jump_pkg::*;
#(
  parameter int unsigned SCORE_W = 8
);

  logic                i_btn;
  logic [X_W-1:0]      i_x_block1;
  logic [X_W-1:0]      i_x_block2;
  logic                i_reload_done;
  logic [STATE_W-1:0]  o_state;
  logic [CHARGE_W-1:0] o_charge;
  logic [X_W-1:0]      o_x_player;
  logic                o_jumping;
  logic                o_reload_start;
  logic [SCORE_W-1:0]  o_score;
  logic                o_game_over;

  modport master (
    output i_btn, i_x_block1, i_x_block2, i_reload_done,
    input  o_state, o_charge, o_x_player, o_jumping, o_reload_start, o_score, o_game_over
  );

  modport slave (
    input  i_btn, i_x_block1, i_x_block2, i_reload_done,
    output o_state, o_charge, o_x_player, o_jumping, o_reload_start, o_score, o_game_over
  );

endinterface

// File: rtl/game_tick_div.sv
// Enable-gated prescaler: tick is high on every DIV-th enabled cycle.
// Ports: clk_machine, rst_machine (async active-low), en (count enable, clears when 0), tick.
module game_tick_div #(
  parameter int unsigned DIV = 2
) (
  input  logic clk_machine,
  input  logic rst_machine,
  input  logic en,
  output logic tick
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q;

  // Count restarts from 0 every time the phase is (re)entered.
  always_ff @(posedge clk_machine or negedge rst_machine) begin
    if (!rst_machine) begin
      cnt_q <= '0;
    end else if (!en || (cnt_q == LAST)) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign tick = en && (cnt_q == LAST);

endmodule

// File: rtl/jump_game_ctrl.sv
// Jump game sequencer: button -> charge/jump/judge phases, player X motion,
// hit/miss against two blocks, reload handshake, score and game-over flag.
// Ports: clk_machine, rst_machine (async active-low), bus (jump_game_ctrl_if.slave).
module jump_game_ctrl
  import jump_pkg::*;
#(
  parameter int unsigned CHARGE_DIV    = 250000,
  parameter int unsigned CHARGE_MAX    = 255,
  parameter int unsigned JUMP_STEP_DIV = 125000,
  parameter int unsigned PLAYER_X0     = 100,
  parameter int unsigned BLOCK_HALF_W  = 20,
  parameter int unsigned SCORE_W       = 8
) (
  input logic             clk_machine,
  input logic             rst_machine,
  jump_game_ctrl_if.slave bus
);

  localparam logic [CHARGE_W-1:0] CMAX = CHARGE_W'(CHARGE_MAX);
  localparam logic [X_W-1:0]      X0   = X_W'(PLAYER_X0);
  localparam logic [X_W:0]        HALF = (X_W+1)'(BLOCK_HALF_W);

  state_t              state_q;
  logic                btn_q;
  logic [CHARGE_W-1:0] charge_q;
  logic [X_W-1:0]      x_q;
  logic [X_W-1:0]      target_q;
  logic [SCORE_W-1:0]  score_q;
  logic                jumping_q;
  logic                reload_q;
  logic                over_q;

  logic rise, fall, charge_tick, step_tick, hit1, hit2;

  assign rise = bus.i_btn & ~btn_q;
  assign fall = ~bus.i_btn & btn_q;
  assign hit1 = abs_dist(x_q, bus.i_x_block1) <= HALF;
  assign hit2 = abs_dist(x_q, bus.i_x_block2) <= HALF;

  game_tick_div #(.DIV(CHARGE_DIV)) u_charge_div (
    .clk_machine (clk_machine),
    .rst_machine (rst_machine),
    .en          (state_q == CHARGE),
    .tick        (charge_tick)
  );

  game_tick_div #(.DIV(JUMP_STEP_DIV)) u_step_div (
    .clk_machine (clk_machine),
    .rst_machine (rst_machine),
    .en          (state_q == JUMP),
    .tick        (step_tick)
  );

  // Sequencer; charge is kept at 0 outside CHARGE/JUMP/JUDGE so it can drive o_charge directly.
  always_ff @(posedge clk_machine or negedge rst_machine) begin
    if (!rst_machine) begin
      state_q   <= IDLE;
      btn_q     <= 1'b0;
      charge_q  <= '0;
      x_q       <= X0;
      target_q  <= X0;
      score_q   <= '0;
      jumping_q <= 1'b0;
      reload_q  <= 1'b0;
      over_q    <= 1'b0;
    end else begin
      btn_q    <= bus.i_btn;
      reload_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (fall) begin
            state_q <= READY;
            score_q <= '0;
            x_q     <= X0;
          end
        end
        READY: begin
          if (rise) begin
            state_q  <= CHARGE;
            charge_q <= '0;
          end
        end
        CHARGE: begin
          if (!bus.i_btn) begin
            state_q   <= JUMP;
            jumping_q <= 1'b1;
            target_q  <= x_q + X_W'(charge_q);
          end else if (charge_tick && (charge_q != CMAX)) begin
            charge_q <= charge_q + CHARGE_W'(1);
          end
        end
        JUMP: begin
          if (x_q == target_q) begin
            state_q   <= JUDGE;
            jumping_q <= 1'b0;
          end else if (step_tick) begin
            x_q <= x_q + X_W'(1);
          end
        end
        JUDGE: begin
          charge_q <= '0;
          if (hit2) begin
            if (score_q != '1) score_q <= score_q + SCORE_W'(1);
            reload_q <= 1'b1;
            state_q  <= RELOAD;
          end else if (hit1) begin
            state_q <= READY;
          end else begin
            state_q <= OVER;
            over_q  <= 1'b1;
          end
        end
        RELOAD: begin
          if (bus.i_reload_done) begin
            x_q      <= X0;
            charge_q <= '0;
            state_q  <= READY;
          end
        end
        OVER: begin
          if (fall) begin
            state_q <= IDLE;
            over_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.o_state        = state_q;
  assign bus.o_charge       = charge_q;
  assign bus.o_x_player     = x_q;
  assign bus.o_jumping      = jumping_q;
  assign bus.o_reload_start = reload_q;
  assign bus.o_score        = score_q;
  assign bus.o_game_over    = over_q;

endmodule

// File: tb/tb_jump_game_ctrl.sv
// Randomized bench for jump_game_ctrl against a round-level game model.
module tb_jump_game_ctrl;
  import jump_pkg::*;

  localparam longint HALF = 20;
  localparam longint X0   = 100;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  jump_game_ctrl_if #(.SCORE_W(8)) bus ();

  jump_game_ctrl #(
    .CHARGE_DIV    (4),
    .CHARGE_MAX    (255),
    .JUMP_STEP_DIV (2),
    .PLAYER_X0     (100),
    .BLOCK_HALF_W  (20),
    .SCORE_W       (8)
  ) dut (
    .clk_machine (clk),
    .rst_machine (rst_n),
    .bus         (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;
  longint m_score;
  longint m_x;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  function automatic longint ldist(input longint a, input longint b);
    return (a > b) ? a - b : b - a;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"}, bus.o_state, 0);
    check({tag, "_charge"}, bus.o_charge, 0);
    check({tag, "_x"}, bus.o_x_player, X0);
    check({tag, "_jumping"}, bus.o_jumping, 0);
    check({tag, "_reload"}, bus.o_reload_start, 0);
    check({tag, "_score"}, bus.o_score, 0);
    check({tag, "_over"}, bus.o_game_over, 0);
  endtask

  // From IDLE with the button released: press and release starts a game.
  task automatic start_game();
    bus.i_btn = 1'b1; step();
    bus.i_btn = 1'b0; step();
    m_score = 0;
    m_x     = X0;
    check("start_state", bus.o_state, 1);
    check("start_score", bus.o_score, m_score);
    check("start_x", bus.o_x_player, m_x);
    check("start_over", bus.o_game_over, 0);
  endtask

  // One charge/jump/judge round from READY with the button released.
  task automatic play_round(input int h, input longint b1, input longint b2,
                            input bit press_in_jump, input int reload_wait, output bit over);
    longint c, prev, x_end;
    int dips, cnt;
    over = 1'b0;
    bus.i_x_block1 = 32'(b1);
    bus.i_x_block2 = 32'(b2);
    bus.i_btn = 1'b1; step();
    check("charge_entry", bus.o_state, 2);
    prev = 0; dips = 0;
    repeat (h) begin
      step();
      if (longint'(bus.o_charge) < prev) dips++;
      prev = longint'(bus.o_charge);
    end
    c = (h / 4 > 255) ? 255 : h / 4;
    check("charge_monotonic", dips, 0);
    check("charge_val", bus.o_charge, c);
    bus.i_btn = 1'b0; step();
    check("jump_state", bus.o_state, 3);
    check("jumping_on", bus.o_jumping, 1);
    check("charge_hold", bus.o_charge, c);
    if (press_in_jump) bus.i_btn = 1'b1;
    cnt = 1;
    while (bus.o_state == 3'd3 && cnt < 2 * c + 20) begin
      step();
      if (bus.o_state == 3'd3) cnt++;
    end
    x_end = m_x + c;
    check("jump_cycles", cnt, 2 * c + 1);
    check("judge_state", bus.o_state, 4);
    check("judge_x", bus.o_x_player, x_end);
    check("judge_charge", bus.o_charge, c);
    check("jumping_off", bus.o_jumping, 0);
    m_x = x_end;
    step();
    if (ldist(x_end, b2) <= HALF) begin
      m_score = (m_score < 255) ? m_score + 1 : 255;
      check("reload_state", bus.o_state, 5);
      check("reload_pulse", bus.o_reload_start, 1);
      check("hit_score", bus.o_score, m_score);
      check("reload_charge", bus.o_charge, 0);
      step();
      check("reload_pulse_once", bus.o_reload_start, 0);
      check("reload_wait", bus.o_state, 5);
      repeat (reload_wait) step();
      bus.i_reload_done = 1'b1; step();
      bus.i_reload_done = 1'b0;
      m_x = X0;
      check("reload_ready", bus.o_state, 1);
      check("reload_x", bus.o_x_player, m_x);
      check("reload_charge0", bus.o_charge, 0);
    end else if (ldist(x_end, b1) <= HALF) begin
      check("stay_state", bus.o_state, 1);
      check("stay_score", bus.o_score, m_score);
      check("stay_x", bus.o_x_player, m_x);
    end else begin
      over = 1'b1;
      check("over_state", bus.o_state, 6);
      check("over_flag", bus.o_game_over, 1);
      check("over_score", bus.o_score, m_score);
    end
  endtask

  // Post-round handling: a held button must not restart charge; OVER returns through IDLE.
  task automatic after_round(input bit held, input bit over);
    if (held && !over) begin
      repeat (2) step();
      check("held_stays_ready", bus.o_state, 1);
      bus.i_btn = 1'b0; step();
      check("release_ready", bus.o_state, 1);
    end
    if (over) begin
      bus.i_btn = 1'b1; step();
      check("over_hold", bus.o_state, 6);
      bus.i_btn = 1'b0; step();
      check("over_to_idle", bus.o_state, 0);
      check("idle_over_clr", bus.o_game_over, 0);
      check("idle_score_kept", bus.o_score, m_score);
      start_game();
    end
  endtask

  initial begin
    bit over;
    bus.i_btn = 1'b0;
    bus.i_x_block1 = '0;
    bus.i_x_block2 = '0;
    bus.i_reload_done = 1'b0;
    m_score = 0;
    m_x = X0;
    repeat (3) step();
    check_reset_outputs("rst");
    rst_n = 1'b1;
    step();
    start_game();

    // Land exactly on block2 after charge 10.
    play_round(40, 100, 110, 1'b0, 2, over);
    after_round(1'b0, over);

    // Land on block1 only, then a stray reload_done in READY is ignored.
    play_round(48, m_x + 12, m_x + 300, 1'b0, 0, over);
    after_round(1'b0, over);
    bus.i_reload_done = 1'b1; step();
    bus.i_reload_done = 1'b0; step();
    check("stray_reload_state", bus.o_state, 1);
    check("stray_reload_x", bus.o_x_player, m_x);

    // Long hold saturates charge at 255.
    play_round(2000, m_x, m_x + 258, 1'b0, 1, over);
    after_round(1'b0, over);

    // Overshoot both blocks: game over, then restart clears score.
    play_round(200, 100, 200, 1'b0, 0, over);
    check("overshoot_is_over", over, 1);
    after_round(1'b0, over);

    // Button held from JUMP through RELOAD and into READY.
    play_round(20, m_x, m_x + 5, 1'b1, 2, over);
    after_round(1'b1, over);
    play_round(20, m_x + 5, m_x + 400, 1'b1, 0, over);
    after_round(1'b1, over);

    // Randomized rounds.
    for (int r = 0; r < 30; r++) begin
      int h;
      longint c, off, b1, b2;
      bit pj;
      h = int'($urandom_range(0, 120));
      c = h / 4;
      off = longint'($urandom_range(0, 50)) - 25;
      case ($urandom_range(0, 2))
        0: begin b2 = m_x + c + off; b1 = m_x; end
        1: begin b1 = m_x + c + off; b2 = m_x + c + 200; end
        default: begin b1 = m_x + c + 60; b2 = m_x + c + 200 + off; end
      endcase
      pj = 1'($urandom_range(0, 1));
      play_round(h, b1, b2, pj, int'($urandom_range(0, 3)), over);
      after_round(pj, over);
    end

    // Score saturation with zero-charge hits.
    for (int r = 0; r < 258; r++) begin
      play_round(0, 0, m_x, 1'b0, 0, over);
      after_round(1'b0, over);
    end
    check("score_saturated", bus.o_score, 255);

    // Asynchronous reset in the middle of a jump.
    bus.i_x_block1 = 32'(m_x);
    bus.i_x_block2 = 32'(m_x + 10);
    bus.i_btn = 1'b1; step();
    repeat (40) step();
    bus.i_btn = 1'b0; step();
    repeat (3) step();
    check("pre_reset_jump", bus.o_state, 3);
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("async_rst");
    step();
    step();
    check_reset_outputs("held_rst");
    rst_n = 1'b1;
    step();
    start_game();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
